axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the single AXI read master port of the core between the DCache (port 0) and the ICache (port 1).
//  It replaces the read half of the 2x1 crossbar with a small in-order arbiter that allows one outstanding burst.
//  Round-robin grant; a grant is held for the whole burst; R beats are routed back to the granted requester.
//  The write channels do not pass through this block; they stay DCache-only.
// PARAMETERS
//  ADDR_WIDTH  32  AR address width
//  DATA_WIDTH  32  R data width
//  ID_WIDTH    4   AXI id width; m_arid = {(ID_WIDTH-1)'0, grant}
// PORTS
//  clk            in   1            core clock
//  rst_n          in   1            asynchronous reset, active low
//  s_arvalid      in   2            per-requester AR valid ([0]=DCache, [1]=ICache)
//  s_arready      out  2            per-requester AR accept
//  s_araddr       in   2xADDR_WIDTH request address
//  s_arlen        in   2x8          burst length minus 1
//  s_arsize       in   2x3          beat size
//  s_arburst      in   2x2          burst type
//  s_rvalid       out  2            per-requester R valid
//  s_rready       in   2            per-requester R ready
//  s_rdata        out  DATA_WIDTH   R data, shared by both requesters
//  s_rresp        out  2            R response, shared
//  s_rlast        out  1            R last, shared
//  m_arid/m_araddr/m_arlen/m_arsize/m_arburst  out  AXI AR fields
//  m_arvalid out 1; m_arready in 1; m_rid in ID_WIDTH; m_rdata in DATA_WIDTH
//  m_rresp in 2; m_rlast in 1; m_rvalid in 1; m_rready out 1
//  busy           out  1            FSM is not in IDLE
//  proto_err      out  1            sticky flag: beat count did not match arlen+1
// BEHAVIOUR
//  - Reset (asynchronous, rst_n=0): state=IDLE, rr_last=1 so that port 0 wins first, beat_cnt=0, proto_err=0.
//    All valid/ready outputs are 0 and every data output is 0. Reset in the middle of a burst abandons the burst; no drain.
//  - FSM has three states: IDLE -> ADDR -> DATA -> IDLE.
//  - IDLE:
//    - If any s_arvalid is set, choose grant. When both are set, grant = ~rr_last; otherwise grant the single requester.
//    - In the same cycle (combinationally), s_arready[grant]=1. The AR fields are latched into registers and the FSM moves to ADDR.
//    - s_arready is only ever 1 in IDLE and only for the winning port.
//  - ADDR:
//    - m_arvalid=1 with the latched fields. They are held stable until m_arready.
//    - On m_arvalid&m_arready: go to DATA, beat_cnt=0.
//    - Minimum latency from s_arvalid to m_arvalid is 1 cycle.
//  - DATA:
//    - s_rvalid[grant]=m_rvalid; m_rready=s_rready[grant]. The other port sees s_rvalid=0.
//    - s_rdata, s_rresp and s_rlast are driven combinationally from the m_r* signals (zero added latency).
//    - Each beat (m_rvalid&m_rready) increments beat_cnt, which is 9 bits wide so it never wraps for arlen<=255.
//    - On the beat with m_rlast: go to IDLE and set rr_last=grant.
//    - proto_err is set if rlast arrives with beat_cnt!=arlen, or if a beat with beat_cnt==arlen has no rlast. In the second case the FSM stays in DATA until rlast.
//    - m_rid is not checked.
//  - m_rready=0 outside DATA. Data beats that arrive outside DATA are not acknowledged.
//  - A request that arrives while the FSM is busy waits (s_arready=0). Requesters must hold their AR fields stable until accepted.
//  - Simultaneous requests alternate strictly. A port that requests alone is granted every time, regardless of rr_last.
//  - Back-to-back bursts: the cycle after the rlast beat is IDLE, so the next grant takes 1 cycle.
// TESTING
//  1. After reset, only s_arvalid[1] is set, addr=0x1c000000, len=3 -> s_arready[1]=1 in cycle 0; m_arvalid in cycle 1 with arid=1; 4 beats appear on s_rvalid[1] only; busy falls after rlast.
//  2. Both ports request every cycle -> grant order is 0,1,0,1. s_arready is never 1 for both ports in the same cycle.
//  3. m_arready is held 0 for 5 cycles -> m_araddr, m_arlen and m_arvalid stay stable; a new s_arvalid[0] is not accepted.
//  4. s_rready[0] toggles 1,0,1,0 during a len=7 burst -> m_rready mirrors it; exactly 8 beats are delivered and beat_cnt ends at 8.
//  5. A len=3 burst where the slave sends rlast on beat 2 -> proto_err=1 (sticky); FSM returns to IDLE.
//  6. rst_n is asserted low mid-DATA, then released -> all outputs are 0 immediately; the next grant goes to port 0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI read arbiter: DCache (port 0) and ICache (port 1) share one
// AR/R master port, round-robin, one outstanding burst, grant held per burst.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 s_arvalid,
    output logic [1:0]                 s_arready,
    input  logic [1:0][ADDR_WIDTH-1:0] s_araddr,
    input  logic [1:0][7:0]            s_arlen,
    input  logic [1:0][2:0]            s_arsize,
    input  logic [1:0][1:0]            s_arburst,
    output logic [1:0]                 s_rvalid,
    input  logic [1:0]                 s_rready,
    output logic [DATA_WIDTH-1:0]      s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rlast,
    output logic [ID_WIDTH-1:0]        m_arid,
    output logic [ADDR_WIDTH-1:0]      m_araddr,
    output logic [7:0]                 m_arlen,
    output logic [2:0]                 m_arsize,
    output logic [1:0]                 m_arburst,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic [ID_WIDTH-1:0]        m_rid,
    input  logic [DATA_WIDTH-1:0]      m_rdata,
    input  logic [1:0]                 m_rresp,
    input  logic                       m_rlast,
    input  logic                       m_rvalid,
    output logic                       m_rready,
    output logic                       busy,
    output logic                       proto_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0] state_q;
    logic       grant_q;
    logic       rr_last_q;
    logic [8:0] beat_cnt;
    logic       grant_d;
    logic       ar_take;
    logic       in_data;
    logic       beat;
    logic [8:0] len9;
    logic       unused_rid;

    assign unused_rid = ^m_rid;

    // Contention goes to the port that did not win last; a lone requester always wins.
    assign grant_d = s_arvalid[1] & (~s_arvalid[0] | ~rr_last_q);
    assign ar_take = (state_q == IDLE) & (|s_arvalid);
    assign in_data = (state_q == DATA);
    assign len9    = {1'b0, m_arlen};

    assign s_arready = ar_take ? (2'b01 << grant_d) : 2'b00;
    assign m_arvalid = (state_q == ADDR);
    assign m_arid    = {{(ID_WIDTH-1){1'b0}}, grant_q};
    assign busy      = (state_q != IDLE);

    // R path is combinational but forced to zero outside DATA.
    assign m_rready = in_data & s_rready[grant_q];
    assign s_rvalid = (in_data & m_rvalid) ? (2'b01 << grant_q) : 2'b00;
    assign s_rdata  = in_data ? m_rdata : '0;
    assign s_rresp  = in_data ? m_rresp : 2'b00;
    assign s_rlast  = in_data & m_rlast;
    assign beat     = in_data & m_rvalid & m_rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            beat_cnt  <= 9'd0;
            proto_err <= 1'b0;
            m_araddr  <= '0;
            m_arlen   <= 8'd0;
            m_arsize  <= 3'd0;
            m_arburst <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_take) begin
                        grant_q   <= grant_d;
                        m_araddr  <= s_araddr[grant_d];
                        m_arlen   <= s_arlen[grant_d];
                        m_arsize  <= s_arsize[grant_d];
                        m_arburst <= s_arburst[grant_d];
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        beat_cnt <= 9'd0;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (m_rlast) begin
                            state_q   <= IDLE;
                            rr_last_q <= grant_q;
                            if (beat_cnt != len9) proto_err <= 1'b1;
                        end else if (beat_cnt == len9) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter.
// Grant order, AR hold, R routing, errors, reset.
module tb_axi_rd_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       s_arvalid;
  logic [1:0]       s_arready;
  logic [1:0][31:0] s_araddr;
  logic [1:0][7:0]  s_arlen;
  logic [1:0][2:0]  s_arsize;
  logic [1:0][1:0]  s_arburst;
  logic [1:0]       s_rvalid;
  logic [1:0]       s_rready;
  logic [31:0]      s_rdata;
  logic [1:0]       s_rresp;
  logic             s_rlast;
  logic [3:0]       m_arid;
  logic [31:0]      m_araddr;
  logic [7:0]       m_arlen;
  logic [2:0]       m_arsize;
  logic [1:0]       m_arburst;
  logic             m_arvalid;
  logic             m_arready;
  logic [3:0]       m_rid;
  logic [31:0]      m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast;
  logic             m_rvalid;
  logic             m_rready;
  logic             busy;
  logic             proto_err;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;
  int nbeats;

  axi_rd_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ID_WIDTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_araddr (s_araddr),
    .s_arlen  (s_arlen),
    .s_arsize (s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid (s_rvalid),
    .s_rready (s_rready),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rlast  (s_rlast),
    .m_arid   (m_arid),
    .m_araddr (m_araddr),
    .m_arlen  (m_arlen),
    .m_arsize (m_arsize),
    .m_arburst(m_arburst),
    .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rid    (m_rid),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rlast  (m_rlast),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready),
    .busy     (busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_tot++;
    if (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    s_arvalid = 2'b00;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_rready  = 2'b00;
    m_arready = 1'b0;
    m_rid     = 4'd0;
    m_rdata   = 32'hDEADBEEF;
    m_rresp   = 2'b10;
    m_rlast   = 1'b1;
    m_rvalid  = 1'b1;

    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_rready", m_rready, 1'b0);
    chk("rst_rvalid", s_rvalid, 2'b00);
    chk("rst_rdata", s_rdata, 32'h0);
    chk("rst_rresp", s_rresp, 2'b00);
    chk("rst_araddr", m_araddr, 32'h0);
    chk("rst_perr", proto_err, 1'b0);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;
    step;
    rst_n = 1'b1;
    step;

    s_arvalid    = 2'b10;
    s_araddr[1]  = 32'h1C000000;
    s_arlen[1]   = 8'd3;
    s_arsize[1]  = 3'd2;
    s_arburst[1] = 2'd1;
    #1;
    chk("t1_arready", s_arready, 2'b10);
    chk("t1_idle", busy, 1'b0);
    step;
    s_arvalid = 2'b00;
    #1;
    chk("t1_arvalid", m_arvalid, 1'b1);
    chk("t1_arid", m_arid, 4'd1);
    chk("t1_araddr", m_araddr, 32'h1C000000);
    chk("t1_arlen", m_arlen, 8'd3);
    chk("t1_arsize", m_arsize, 3'd2);
    chk("t1_arburst", m_arburst, 2'd1);
    chk("t1_busy", busy, 1'b1);
    m_arready = 1'b1;
    step;
    m_arready = 1'b0;
    chk("t1_arvalid_drop", m_arvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hA0 + 32'(i);
      m_rlast  = (i == 3);
      s_rready = 2'b10;
      #1;
      chk("t1_rvalid", s_rvalid, 2'b10);
      chk("t1_rdata", s_rdata, 32'hA0 + 32'(i));
      chk("t1_rlast", s_rlast, (i == 3));
      chk("t1_rready", m_rready, 1'b1);
      step;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b00;
    #1;
    chk("t1_done", busy, 1'b0);

    s_araddr[0] = 32'h1000;
    s_araddr[1] = 32'h2000;
    s_arlen[0]  = 8'd0;
    s_arlen[1]  = 8'd0;
    s_arvalid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_arready", s_arready,
          ((k % 2) == 1) ? 2'b10 : 2'b01);
      step;
      m_arready = 1'b1;
      #1;
      chk("t2_arid", m_arid,
          ((k % 2) == 1) ? 4'd1 : 4'd0);
      chk("t2_araddr", m_araddr,
          ((k % 2) == 1) ? 32'h2000 : 32'h1000);
      chk("t2_busy_ar", s_arready, 2'b00);
      step;
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      s_rready  = 2'b11;
      #1;
      chk("t2_rvalid", s_rvalid,
          ((k % 2) == 1) ? 2'b10 : 2'b01);
      step;
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
    end
    s_arvalid = 2'b00;
    s_rready  = 2'b00;

    s_arvalid   = 2'b01;
    s_araddr[0] = 32'h3000;
    s_arlen[0]  = 8'd5;
    #1;
    chk("t3_arready", s_arready, 2'b01);
    step;
    s_araddr[0] = 32'h4000;
    s_arlen[0]  = 8'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_arvalid", m_arvalid, 1'b1);
      chk("t3_araddr", m_araddr, 32'h3000);
      chk("t3_arlen", m_arlen, 8'd5);
      chk("t3_no_accept", s_arready, 2'b00);
      step;
    end
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    step;
    m_arready = 1'b0;
    s_rready  = 2'b01;
    for (int i = 0; i < 6; i++) begin
      m_rvalid = 1'b1;
      m_rlast  = (i == 5);
      #1;
      chk("t3_rvalid", s_rvalid, 2'b01);
      step;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    chk("t3_busy", busy, 1'b0);
    chk("t3_perr", proto_err, 1'b0);

    s_arvalid   = 2'b01;
    s_araddr[0] = 32'h5000;
    s_arlen[0]  = 8'd7;
    step;
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    step;
    m_arready = 1'b0;
    nbeats    = 0;
    for (int i = 0; i < 16; i++) begin
      m_rvalid = 1'b1;
      s_rready = ((i % 2) == 0) ? 2'b01 : 2'b00;
      m_rdata  = 32'(i / 2);
      m_rlast  = ((i / 2) == 7);
      #1;
      chk("t4_rready", m_rready, ((i % 2) == 0));
      if (s_rvalid[0] && s_rready[0]) nbeats++;
      step;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b00;
    #1;
    chk("t4_beats", nbeats, 8);
    chk("t4_beat_cnt", dut.beat_cnt, 9'd8);
    chk("t4_busy", busy, 1'b0);
    chk("t4_perr", proto_err, 1'b0);

    s_arvalid   = 2'b10;
    s_araddr[1] = 32'h6000;
    s_arlen[1]  = 8'd3;
    step;
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    step;
    m_arready = 1'b0;
    s_rready  = 2'b10;
    for (int i = 0; i < 3; i++) begin
      m_rvalid = 1'b1;
      m_rlast  = (i == 2);
      step;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b00;
    #1;
    chk("t5_perr", proto_err, 1'b1);
    chk("t5_idle", busy, 1'b0);
    step;
    step;
    chk("t5_sticky", proto_err, 1'b1);

    s_arvalid   = 2'b01;
    s_araddr[0] = 32'h7000;
    s_arlen[0]  = 8'd3;
    step;
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    step;
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'hFFFF;
    s_rready  = 2'b01;
    step;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_rready", m_rready, 1'b0);
    chk("t6_rvalid", s_rvalid, 2'b00);
    chk("t6_rdata", s_rdata, 32'h0);
    chk("t6_araddr", m_araddr, 32'h0);
    chk("t6_perr", proto_err, 1'b0);
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    step;
    rst_n       = 1'b1;
    s_araddr[0] = 32'h8000;
    s_araddr[1] = 32'h9000;
    s_arvalid   = 2'b11;
    #1;
    chk("t6_arready", s_arready, 2'b01);
    step;
    s_arvalid = 2'b00;
    #1;
    chk("t6_arid", m_arid, 4'd0);
    chk("t6_araddr2", m_araddr, 32'h8000);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
